ttt_board_engine: RTL and testbench

//  Parametrised N x N, K-in-a-row game engine; the successor to the fixed 3x3 board/turn logic.

---
 rtl/ttt_board_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_ttt_board_engine.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_board_engine.sv
// N x N, K-in-a-row game engine: board storage, turn order, move legality and win/draw detection.
// Optional single-level undo is compiled in when TTT_UNDO_EN is defined.
module ttt_board_engine #(
    parameter  int N       = 3,
    parameter  int WIN_LEN = 3,
    localparam int IDX_W   = $clog2(N * N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [IDX_W-1:0]   move_idx,
    input  logic               undo,
    output logic               is_main,
    output logic               turn_o,
    output logic               busy,
    output logic               move_ok,
    output logic               move_err,
    output logic [2*N*N-1:0]   board,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam int                     CELLS     = N * N;
    localparam int                     CNT_W     = $clog2(CELLS + 1);
    localparam logic [IDX_W:0]         CELLS_X   = (IDX_W + 1)'(CELLS);
    localparam logic [CNT_W-1:0]       CELLS_C   = CNT_W'(CELLS);
    localparam logic signed [7:0]      N_S       = 8'(N);
    localparam logic [2:0]             LAST_STEP = 3'(WIN_LEN - 1);
    localparam logic [3:0]             RUN_NEED  = 4'(WIN_LEN - 1);

    if (N < 3 || N > 8 || WIN_LEN < 3 || WIN_LEN > N) begin : g_param_check
        $error("ttt_board_engine: need 3 <= N <= 8 and 3 <= WIN_LEN <= N");
    end

    typedef enum logic [1:0] {S_MAIN, S_WAIT, S_CHECK, S_OVER} state_e;

    state_e             state_q, state_d;
    logic [1:0]         cell_q [CELLS];
    logic [CNT_W-1:0]   count_q;
    logic [2:0]         last_row_q, last_col_q;
    logic [2:0]         dir_q;
    logic [2:0]         step_q;
    logic [3:0]         run_q;
    logic               alive_q;
    logic               win_q;

    logic               legal, accept, reject;
    logic [1:0]         mark;
    logic [1:0]         line;
    logic               neg;
    logic signed [7:0]  step_s, row_off, col_off, probe_r, probe_c;
    logic               in_bounds, probe_hit, win_now, chk_last;
    logic [IDX_W-1:0]   probe_idx;
    logic [3:0]         run_base, run_nxt;

`ifdef TTT_UNDO_EN
    logic [IDX_W-1:0]   last_idx_q;
    logic               slot_q;
    logic               undo_go;
`else
    logic               undo_unused;
    assign undo_unused = undo;
`endif

    assign is_main   = (state_q == S_MAIN);
    assign busy      = (state_q == S_CHECK);
    assign game_over = (state_q == S_OVER);
    assign mark      = turn_o ? 2'b10 : 2'b01;

    for (genvar g = 0; g < CELLS; g++) begin : g_board
        assign board[2*g +: 2] = cell_q[g];
    end

    // Move decode: only WAIT reacts to requests, and new_game overrides everything.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        legal   = ({1'b0, move_idx} < CELLS_X) && (cell_q[move_idx] == 2'b00);
        accept  = 1'b0;
        reject  = 1'b0;
`ifdef TTT_UNDO_EN
        undo_go = 1'b0;
        if (state_q == S_WAIT && !new_game) begin
            if (move_valid && undo) begin
                reject = 1'b1;
            end else if (move_valid) begin
                accept = legal;
                reject = !legal;
            end else if (undo) begin
                undo_go = (count_q != '0) && slot_q;
                reject  = !undo_go;
            end
        end
`else
        if (state_q == S_WAIT && !new_game && move_valid) begin
            accept = legal;
            reject = !legal;
        end
`endif
    end

    // Scan probe: dir_q[2:1] picks H/V/diag/anti-diag, dir_q[0] picks the negative side.
    always_comb begin
        line    = dir_q[2:1];
        neg     = dir_q[0];
        step_s  = $signed({5'b00000, step_q});
        row_off = (line == 2'd0) ? 8'sd0 : (neg ? -step_s : step_s);
        case (line)
            2'd1:    col_off = 8'sd0;
            2'd3:    col_off = neg ? step_s : -step_s;
            default: col_off = neg ? -step_s : step_s;
        endcase
        probe_r   = $signed({5'b00000, last_row_q}) + row_off;
        probe_c   = $signed({5'b00000, last_col_q}) + col_off;
        in_bounds = (probe_r >= 8'sd0) && (probe_r < N_S) && (probe_c >= 8'sd0) && (probe_c < N_S);
        probe_idx = IDX_W'(probe_r * N_S + probe_c);
        probe_hit = ((step_q == 3'd1) || alive_q) && in_bounds && (cell_q[probe_idx] == mark);
        run_base  = (step_q == 3'd1 && !neg) ? 4'd0 : run_q;
        run_nxt   = run_base + {3'b000, probe_hit};
        win_now   = win_q || (run_nxt >= RUN_NEED);
        chk_last  = (dir_q == 3'd7) && (step_q == LAST_STEP);
    end

    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = S_MAIN;
        end else begin
            case (state_q)
                S_MAIN:  if (start) state_d = S_WAIT;
                S_WAIT:  if (accept) state_d = S_CHECK;
                S_CHECK: if (chk_last) state_d = (win_now || count_q == CELLS_C) ? S_OVER : S_WAIT;
                S_OVER:  state_d = S_OVER;
                default: state_d = S_MAIN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst) state_q <= S_MAIN;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: board cells are reset like ordinary flops; the game needs a known empty board.
            for (int i = 0; i < CELLS; i++) cell_q[i] <= 2'b00;
            count_q    <= '0;
            last_row_q <= '0;
            last_col_q <= '0;
            dir_q      <= '0;
            step_q     <= 3'd1;
            run_q      <= '0;
            alive_q    <= 1'b0;
            win_q      <= 1'b0;
            turn_o     <= 1'b0;
            move_ok    <= 1'b0;
            move_err   <= 1'b0;
            winner     <= 2'b00;
`ifdef TTT_UNDO_EN
            last_idx_q <= '0;
            slot_q     <= 1'b0;
`endif
        end else begin
            move_ok  <= accept;
            move_err <= reject;
            if (new_game) begin
                for (int i = 0; i < CELLS; i++) cell_q[i] <= 2'b00;
                count_q    <= '0;
                last_row_q <= '0;
                last_col_q <= '0;
                dir_q      <= '0;
                step_q     <= 3'd1;
                run_q      <= '0;
                alive_q    <= 1'b0;
                win_q      <= 1'b0;
                turn_o     <= 1'b0;
                winner     <= 2'b00;
`ifdef TTT_UNDO_EN
                last_idx_q <= '0;
                slot_q     <= 1'b0;
`endif
            end else begin
                if (accept) begin
                    cell_q[move_idx] <= mark;
                    count_q          <= count_q + CNT_W'(1);
                    last_row_q       <= 3'(move_idx / N);
                    last_col_q       <= 3'(move_idx % N);
                    dir_q            <= '0;
                    step_q           <= 3'd1;
                    run_q            <= '0;
                    alive_q          <= 1'b1;
                    win_q            <= 1'b0;
`ifdef TTT_UNDO_EN
                    last_idx_q       <= move_idx;
                    slot_q           <= 1'b1;
`endif
                end
`ifdef TTT_UNDO_EN
                if (undo_go) begin
                    cell_q[last_idx_q] <= 2'b00;
                    count_q            <= count_q - CNT_W'(1);
                    turn_o             <= ~turn_o;
                    slot_q             <= 1'b0;
                end
`endif
                if (state_q == S_CHECK) begin
                    run_q   <= run_nxt;
                    alive_q <= probe_hit;
                    win_q   <= win_now;
                    if (step_q == LAST_STEP) begin
                        step_q <= 3'd1;
                        dir_q  <= dir_q + 3'd1;
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                    // Decision uses this cycle's probe too, so the last cell scanned still counts.
                    if (chk_last) begin
                        if (win_now)                 winner <= mark;
                        else if (count_q == CELLS_C) winner <= 2'b11;
                        else                         turn_o <= ~turn_o;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ttt_board_engine.sv
// Bench for ttt_board_engine: a 3x3/3 unit and a 5x5/4 unit checked every cycle against a
// whole-board reference model, plus literal expectations along the directed game scripts.
module tb_ttt_board_engine;

    localparam int CHK3 = 16;
    localparam int CHK5 = 24;
`ifdef TTT_UNDO_EN
    localparam bit UNDO_EN = 1'b1;
`else
    localparam bit UNDO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_start = 0, a_new = 0, a_mv = 0, a_undo = 0;
    logic [3:0]  a_idx = '0;
    logic        a_main, a_turn, a_busy, a_ok, a_err, a_over;
    logic [1:0]  a_win;
    logic [17:0] a_board;

    logic        b_start = 0, b_new = 0, b_mv = 0, b_undo = 0;
    logic [4:0]  b_idx = '0;
    logic        b_main, b_turn, b_busy, b_ok, b_err, b_over;
    logic [1:0]  b_win;
    logic [49:0] b_board;

    ttt_board_engine #(.N(3), .WIN_LEN(3)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .new_game(a_new), .move_valid(a_mv),
        .move_idx(a_idx), .undo(a_undo), .is_main(a_main), .turn_o(a_turn), .busy(a_busy),
        .move_ok(a_ok), .move_err(a_err), .board(a_board), .game_over(a_over), .winner(a_win)
    );

    ttt_board_engine #(.N(5), .WIN_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .new_game(b_new), .move_valid(b_mv),
        .move_idx(b_idx), .undo(b_undo), .is_main(b_main), .turn_o(b_turn), .busy(b_busy),
        .move_ok(b_ok), .move_err(b_err), .board(b_board), .game_over(b_over), .winner(b_win)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(string name, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 main, 1 wait, 2 check, 3 over; marks 1 = X, 2 = O.
    int m_n [2] = '{3, 5};
    int m_k [2] = '{3, 4};
    int m_cell [2][64];
    int m_phase [2], m_turn [2], m_cnt [2], m_chk [2];
    int m_ok [2], m_err [2], m_win [2], m_last [2], m_slot [2];

    function automatic bit has_line(int u, int mark);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        int n = m_n[u];
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int d = 0; d < 4; d++) begin
                    int hits = 0;
                    for (int s = 0; s < m_k[u]; s++) begin
                        int rr = r + s * dr[d];
                        int cc = c + s * dc[d];
                        if (rr >= 0 && rr < n && cc >= 0 && cc < n && m_cell[u][rr*n+cc] == mark) hits++;
                    end
                    if (hits == m_k[u]) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic model_reset(int u);
        for (int i = 0; i < 64; i++) m_cell[u][i] = 0;
        m_phase[u] = 0; m_turn[u] = 0; m_cnt[u] = 0; m_chk[u] = 0;
        m_ok[u] = 0; m_err[u] = 0; m_win[u] = 0; m_last[u] = 0; m_slot[u] = 0;
    endtask

    task automatic model_step(int u, bit st, bit ng, bit mv, int idx, bit un);
        int n2 = m_n[u] * m_n[u];
        m_ok[u]  = 0;
        m_err[u] = 0;
        if (ng) begin
            model_reset(u);
            return;
        end
        case (m_phase[u])
            0: if (st) m_phase[u] = 1;
            1: begin
                if (UNDO_EN && mv && un) begin
                    m_err[u] = 1;
                end else if (mv) begin
                    if (idx < n2 && m_cell[u][idx] == 0) begin
                        m_cell[u][idx] = m_turn[u] + 1;
                        m_cnt[u]++;
                        m_last[u]  = idx;
                        m_slot[u]  = 1;
                        m_ok[u]    = 1;
                        m_chk[u]   = (u == 0) ? CHK3 : CHK5;
                        m_phase[u] = 2;
                    end else begin
                        m_err[u] = 1;
                    end
                end else if (UNDO_EN && un) begin
                    if (m_cnt[u] > 0 && m_slot[u] != 0) begin
                        m_cell[u][m_last[u]] = 0;
                        m_cnt[u]--;
                        m_turn[u] ^= 1;
                        m_slot[u] = 0;
                    end else begin
                        m_err[u] = 1;
                    end
                end
            end
            2: begin
                m_chk[u]--;
                if (m_chk[u] == 0) begin
                    if (has_line(u, m_turn[u] + 1)) begin
                        m_win[u] = m_turn[u] + 1; m_phase[u] = 3;
                    end else if (m_cnt[u] == n2) begin
                        m_win[u] = 3; m_phase[u] = 3;
                    end else begin
                        m_turn[u] ^= 1; m_phase[u] = 1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, a_start, a_new, a_mv, int'(a_idx), a_undo);
            model_step(1, b_start, b_new, b_mv, int'(b_idx), b_undo);
        end
    end

    function automatic logic [127:0] model_board(int u);
        logic [127:0] b = '0;
        for (int i = 0; i < m_n[u] * m_n[u]; i++) b[2*i +: 2] = 2'(m_cell[u][i]);
        return b;
    endfunction

    task automatic cmp_unit(int u, logic im, logic tu, logic bs, logic ok, logic er,
                            logic ov, logic [1:0] w, logic [127:0] bd);
        string p = (u == 0) ? "a" : "b";
        check({p, " is_main"},   128'(im), 128'(m_phase[u] == 0));
        check({p, " turn_o"},    128'(tu), 128'(m_turn[u]));
        check({p, " busy"},      128'(bs), 128'(m_phase[u] == 2));
        check({p, " move_ok"},   128'(ok), 128'(m_ok[u]));
        check({p, " move_err"},  128'(er), 128'(m_err[u]));
        check({p, " game_over"}, 128'(ov), 128'(m_phase[u] == 3));
        check({p, " winner"},    128'(w),  128'(m_win[u]));
        check({p, " board"},     bd,       model_board(u));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_unit(0, a_main, a_turn, a_busy, a_ok, a_err, a_over, a_win, 128'(a_board));
            cmp_unit(1, b_main, b_turn, b_busy, b_ok, b_err, b_over, b_win, 128'(b_board));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic move_a(int idx);
        a_idx = 4'(idx); a_mv = 1'b1;
        @(negedge clk);
        a_mv = 1'b0;
    endtask

    task automatic move_b(int idx);
        b_idx = 5'(idx); b_mv = 1'b1;
        @(negedge clk);
        b_mv = 1'b0;
    endtask

    task automatic play_a(int idx);
        move_a(idx);
        cyc(CHK3);
    endtask

    task automatic play_b(int idx);
        move_b(idx);
        cyc(CHK5);
    endtask

    task automatic restart_a();
        a_new = 1'b1;
        @(negedge clk);
        a_new = 1'b0; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int b_seq1 [7]   = '{3, 20, 4, 22, 5, 24, 6};
    int b_seq2 [6]   = '{1, 0, 2, 12, 7, 18};
    int busy_cnt;

    initial begin
        #2 rst = 1'b0;
        cmp_en = 1'b1;
        cyc(2);
        check("reset a is_main", 128'(a_main), 128'(1));
        check("reset a board",   128'(a_board), 128'(0));
        check("reset b winner",  128'(b_win), 128'(0));
        rst = 1'b1;
        cyc(1);

        a_start = 1'b1; b_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0;
        check("start a leaves main", 128'(a_main), 128'(0));

        // First X move at the centre and the fixed-length scan.
        move_a(4);
        check("x4 move_ok", 128'(a_ok), 128'(1));
        check("x4 board",   128'(a_board), 128'h100);
        busy_cnt = 0;
        for (int t = 0; t < 40 && a_busy; t++) begin
            busy_cnt++;
            @(negedge clk);
        end
        check("x4 busy cycles", 128'(busy_cnt), 128'(16));
        check("x4 turn after",  128'(a_turn), 128'(1));

        move_a(4);
        check("o4 move_err",   128'(a_err), 128'(1));
        check("o4 board same", 128'(a_board), 128'h100);
        check("o4 turn same",  128'(a_turn), 128'(1));
        move_a(9);
        check("idx9 move_err", 128'(a_err), 128'(1));
        cyc(1);
`ifndef TTT_UNDO_EN
        a_undo = 1'b1;
        @(negedge clk);
        a_undo = 1'b0;
        check("undo ignored err", 128'(a_err), 128'(0));
        check("undo ignored board", 128'(a_board), 128'h100);
`endif

        // X wins along the top row; a request during CHECK is dropped.
        restart_a();
        move_a(0);
        move_a(5);
        check("move in check no ok",  128'(a_ok), 128'(0));
        check("move in check no err", 128'(a_err), 128'(0));
        cyc(CHK3);
        play_a(3); play_a(1); play_a(4); play_a(2);
        check("row win game_over", 128'(a_over), 128'(1));
        check("row win winner",    128'(a_win), 128'(1));
        move_a(8);
        check("over move no ok",  128'(a_ok), 128'(0));
        check("over move no err", 128'(a_err), 128'(0));
        cyc(2);

        restart_a();
        foreach (draw_seq[i]) play_a(draw_seq[i]);
        check("draw winner",    128'(a_win), 128'(3));
        check("draw game_over", 128'(a_over), 128'(1));

        a_new = 1'b1; a_start = 1'b1;
        @(negedge clk);
        a_new = 1'b0; a_start = 1'b0;
        check("new_game beats start", 128'(a_main), 128'(1));
        check("new_game clears board", 128'(a_board), 128'(0));

`ifdef TTT_UNDO_EN
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        play_a(4);
        a_undo = 1'b1;
        @(negedge clk);
        a_undo = 1'b0;
        check("undo board", 128'(a_board), 128'(0));
        check("undo turn",  128'(a_turn), 128'(0));
        a_undo = 1'b1;
        @(negedge clk);
        a_undo = 1'b0;
        check("second undo err", 128'(a_err), 128'(1));
        a_undo = 1'b1; a_idx = 4'd2; a_mv = 1'b1;
        @(negedge clk);
        a_undo = 1'b0; a_mv = 1'b0;
        check("undo with move err", 128'(a_err), 128'(1));
        check("undo with move board", 128'(a_board), 128'(0));
        a_new = 1'b1; a_start = 1'b1;
        @(negedge clk);
        a_new = 1'b0; a_start = 1'b0;
        check("undo build new_game main", 128'(a_main), 128'(1));
`endif

        // 5x5 / 4: X on 3,4,5,6 is not a row because rows do not wrap; then a 4-diagonal wins.
        foreach (b_seq1[i]) play_b(b_seq1[i]);
        check("b no wrap win", 128'(b_over), 128'(0));
        check("b turn after",  128'(b_turn), 128'(1));
        foreach (b_seq2[i]) play_b(b_seq2[i]);
        check("b diag game_over", 128'(b_over), 128'(1));
        check("b diag winner",    128'(b_win), 128'(1));

        // Reset in the middle of a scan leaves nothing behind.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        move_a(4);
        cyc(5);
        #2 rst = 1'b0;
        @(negedge clk);
        check("mid reset busy",  128'(a_busy), 128'(0));
        check("mid reset main",  128'(a_main), 128'(1));
        check("mid reset board", 128'(a_board), 128'(0));
        rst = 1'b1;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
